// File: rtl/forward_hazard_unit.sv
// Forwarding and hazard-detection controller for the 5-stage MIPS pipeline.
// The FORWARD_HAZARD_FWD_EN macro enables EX/MEM and MEM/WB forwarding.
// Without it, every live dependence stalls.
module forward_hazard_unit #(
  parameter int REG_BITS  = 5,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_BITS-1:0]  if_id_rs,
  input  logic [REG_BITS-1:0]  if_id_rt,
  input  logic                 if_id_uses_rt,
  input  logic [REG_BITS-1:0]  id_ex_rs,
  input  logic [REG_BITS-1:0]  id_ex_rt,
  input  logic [REG_BITS-1:0]  id_ex_dest,
  input  logic                 id_ex_regwrite,
  input  logic                 id_ex_memread,
  input  logic                 flush,
  output logic [1:0]           ForwardA,
  output logic [1:0]           ForwardB,
  output logic                 stall,
  output logic                 bubble,
  output logic [CNT_WIDTH-1:0] stall_count
);

  typedef enum logic {RUN, STALL} state_t;

  state_t                state_q, state_d;
  logic [REG_BITS:0]     mem_tag_q, mem_tag_d;
  logic [REG_BITS:0]     wb_tag_q, wb_tag_d;
  logic [CNT_WIDTH-1:0]  stall_count_q, stall_count_d;

  logic [REG_BITS-1:0]   mem_dest, wb_dest;
  logic                  mem_live, wb_live, ex_live;
  logic                  hz;

  assign mem_dest = mem_tag_q[REG_BITS-1:0];
  assign wb_dest  = wb_tag_q[REG_BITS-1:0];
  // A tag writing $0 can never supply a value, so it is treated as absent.
  assign mem_live = mem_tag_q[REG_BITS] && (mem_dest != '0);
  assign wb_live  = wb_tag_q[REG_BITS]  && (wb_dest  != '0);
  assign ex_live  = id_ex_regwrite      && (id_ex_dest != '0);

`ifdef FORWARD_HAZARD_FWD_EN
  always_comb begin
    ForwardA = 2'b00;
    ForwardB = 2'b00;
    hz       = 1'b0;
    if (mem_live && (mem_dest == id_ex_rs))     ForwardA = 2'b10;
    else if (wb_live && (wb_dest == id_ex_rs))  ForwardA = 2'b01;
    if (mem_live && (mem_dest == id_ex_rt))     ForwardB = 2'b10;
    else if (wb_live && (wb_dest == id_ex_rt))  ForwardB = 2'b01;
    // Only a load result is too late for EX/MEM forwarding.
    if (id_ex_memread && (id_ex_dest != '0) &&
        ((id_ex_dest == if_id_rs) || (if_id_uses_rt && (id_ex_dest == if_id_rt))))
      hz = 1'b1;
  end
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{id_ex_rs, id_ex_rt, id_ex_memread, wb_live};

  always_comb begin
    ForwardA = 2'b00;
    ForwardB = 2'b00;
    hz       = 1'b0;
    // WB is written before the ID read, so only EX and MEM producers stall.
    if (ex_live && ((id_ex_dest == if_id_rs) ||
                    (if_id_uses_rt && (id_ex_dest == if_id_rt))))
      hz = 1'b1;
    if (mem_live && ((mem_dest == if_id_rs) ||
                     (if_id_uses_rt && (mem_dest == if_id_rt))))
      hz = 1'b1;
  end
`endif

`ifdef FORWARD_HAZARD_FWD_EN
  logic unused_ex_live;
  assign unused_ex_live = ex_live;
`endif

  always_comb begin
    state_d       = state_q;
    stall         = 1'b0;
    mem_tag_d     = {id_ex_regwrite, id_ex_dest};
    wb_tag_d      = mem_tag_q;
    stall_count_d = stall_count_q;
    // The stall equation is the same in both states; rst gates it so a
    // held reset forces the outputs low at once.
    case (state_q)
      RUN:     stall = hz && !flush && rst;
      STALL:   stall = hz && !flush && rst;
      default: stall = 1'b0;
    endcase
    state_d = stall ? STALL : RUN;
    if (stall && (stall_count_q != '1))
      stall_count_d = stall_count_q + 1'b1;
  end

  assign bubble      = stall;
  assign stall_count = stall_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      mem_tag_q     <= '0;
      wb_tag_q      <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      mem_tag_q     <= mem_tag_d;
      wb_tag_q      <= wb_tag_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: doc/forward_hazard_unit.md
# forward_hazard_unit

Forwarding and hazard-detection controller for the 5-stage MIPS pipeline. It consumes the register identities held in the IF/ID and ID/EX pipeline registers and tracks in-flight destination tags for the EX/MEM and MEM/WB stages internally. From these it drives the ForwardA/ForwardB selects into the EX operand muxes, plus the stall/bubble controls for the PC, IF/ID and ID/EX registers.

## Interface
- REG_BITS, 5, register-specifier width
- CNT_WIDTH, 16, width of the stall-cycle counter

- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-low reset
- if_id_rs  input  REG_BITS  rs of the instruction in ID
- if_id_rt  input  REG_BITS  rt of the instruction in ID
- if_id_uses_rt  input  1  ID instruction reads rt (R-type, store, beq/bne)
- id_ex_rs  input  REG_BITS  rs of the instruction in EX
- id_ex_rt  input  REG_BITS  rt of the instruction in EX
- id_ex_dest  input  REG_BITS  destination of the EX instruction, after the RegDst mux
- id_ex_regwrite  input  1  EX instruction writes the register file
- id_ex_memread  input  1  EX instruction is a load
- flush  input  1  branch/jump taken; the ID instruction is being killed
- ForwardA  output  2  EX operand A select: 00 regfile, 10 EX/MEM ALU result, 01 WB data
- ForwardB  output  2  EX operand B select, same encoding
- stall  output  1  hold PC and IF/ID
- bubble  output  1  load zero controls into ID/EX next edge
- stall_count  output  CNT_WIDTH  saturating count of stall cycles since reset

## Operation
- Tag pipeline, registered on each rising edge:
  - mem_tag <= {id_ex_regwrite, id_ex_dest}
  - wb_tag <= mem_tag
  - The EX contents are captured whether or not a bubble is being inserted, because bubbles arrive already zeroed via ID/EX.
- Register 0 never matches. Any tag with dest==0 or write-enable 0 is inert.
- Forwarding (macro defined), ForwardA:
  - 10 if mem_wr && mem_dest==id_ex_rs.
  - Else 01 if wb_wr && wb_dest==id_ex_rs.
  - Else 00.
  - When MEM and WB both match, MEM wins.
  - ForwardB: identical, using id_ex_rt.
- Load-use hazard: hz = id_ex_memread && id_ex_dest!=0 && (id_ex_dest==if_id_rs || (if_id_uses_rt && id_ex_dest==if_id_rt)).
- State machine, two states:
  - RUN: stall=bubble=hz && !flush. Go to STALL when they assert.
  - STALL: re-evaluate with the same equations; return to RUN when deasserted.
  - Back-to-back stalls are allowed.
- flush has priority: stall=bubble=0 in the flush cycle, whatever the hazard.
- stall_count increments on every cycle with stall=1 and saturates at all-ones.

## Timing
- ForwardA, ForwardB, stall and bubble are combinational from the inputs and the registered tags, with zero-cycle latency. The consuming registers act on the next rising edge.
- Load-use costs exactly 1 stall cycle. On the following cycle the load occupies WB and the consumer in EX receives ForwardX=01.
- Reset (rst=0, asynchronous):
  - tags cleared, FSM in RUN, stall_count=0
  - all outputs 0 while reset is held
- Reset asserted mid-stall drops stall/bubble immediately. The first cycle after release evaluates from cleared tags.

## Configuration
- FORWARD_HAZARD_FWD_EN defined: forwarding as above; only load-use stalls.
- Not defined:
  - ForwardA/ForwardB are tied to 00.
  - stall=bubble=1 while the ID instruction's rs (or rt when if_id_uses_rt) matches a live destination in EX (id_ex_regwrite/id_ex_dest) or in mem_tag.
  - The register file is write-before-read, so WB never stalls.
  - A dependence on an ALU op therefore costs up to 2 cycles; a load behaves the same as an ALU op.
  - flush priority and stall_count are unchanged.

## Test plan
- **EX/MEM forward.** add $3 then sub $5,$3,$4 back-to-back (FWD_EN defined) → ForwardA=10 in sub's EX cycle, stall never asserts.
- **MEM/WB forward and double match.** $3 written two instructions ahead → ForwardB=01. With $3 written at both MEM and WB → 10.
- **Load-use.** lw $2 followed by add $4,$2,$2 → stall=bubble=1 for exactly 1 cycle, then ForwardA=ForwardB=01, stall_count=1.
- **Register 0 and rt-unused.** A write to $0 followed by a reader of $0 → outputs 00. lw $7 followed by addi using rt=$7 with if_id_uses_rt=0 → no stall.
- **Flush priority.** Load-use hazard present with flush=1 in the same cycle → stall=bubble=0, stall_count unchanged.
- **No-forwarding build and reset.** FWD_EN undefined, add $3 then sub using $3 → 2 stall cycles, Forward 00. Reset asserted during the second stall cycle → all outputs 0 at once, stall_count=0.
